mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
Parametrised N-channel, W-bit multiplexer with registered output and a built-in channel sequencer. In manual mode it follows an external select. In scan mode it steps through all channels automatically, dwelling a fixed number of cycles on each. It feeds display/LED multiplexing and signal-sampling stages in the lab designs, replacing chains of fixed 2:1/4:1 muxes.

Parameters:
WIDTH, 4, bits per channel (>=1)
CHANNELS, 4, number of input channels (>=1)
SEL_W, 2, select/pointer width; must satisfy 2^SEL_W >= CHANNELS
DWELL, 8, clock cycles spent on each channel in scan mode (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
d  input  WIDTH*CHANNELS  packed channels; channel k = d[k*WIDTH +: WIDTH]
sel  input  SEL_W  manual channel select / scan preload value
mode  input  1  0 = manual, 1 = scan
load  input  1  scan mode: preload pointer from sel
y  output  WIDTH  registered selected data
ch  output  SEL_W  channel currently driving y
valid  output  1  one-cycle pulse when ch changes value
wrap  output  1  one-cycle pulse when scan pointer advances from last channel back to first

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset:
  - y=0, ch=0, valid=0, wrap=0.
  - Dwell counter cnt=0.
  - FSM=MANUAL.
  - All other inputs are ignored while reset=1.
- Each cycle: compute nxt_ch, then register ch<=nxt_ch and y<=d[nxt_ch]. y and ch are always consistent. Latency from d or sel to y is 1 clock.
- FSM states:
  - MANUAL: stays while mode=0; goes to SCAN when mode=1.
  - SCAN: stays while mode=1; goes to MANUAL when mode=0.
  - mode is sampled every cycle. The transition and the new state's nxt_ch rule apply in the same cycle.
- MANUAL:
  - nxt_ch = sel if sel < CHANNELS, else ch unchanged (out-of-range select ignored).
  - cnt is held at 0.
- SCAN:
  - Entry starts from the current ch with cnt=0.
  - If load=1: nxt_ch = sel if in range, else ch; cnt<=0. load has priority over advance.
  - Else if cnt==DWELL-1: cnt<=0 and nxt_ch=ch+1, or 0 if ch==CHANNELS-1. In the wrap case, wrap<=1.
  - Else: cnt<=cnt+1 and nxt_ch=ch.
- valid <= (nxt_ch != ch). It never asserts while ch is constant, even though y still tracks a changing d.
- wrap is only asserted in SCAN, on a natural advance. It is not asserted on load.
- Boundaries:
  - DWELL=1: advance every cycle.
  - CHANNELS=1: ch stays 0; wrap pulses every DWELL cycles; valid never pulses.
  - Mode switch mid-dwell discards the partial count.
  - reset mid-scan overrides load and mode in that cycle.

Optional Feature:
MUX_SKIP_MASK_EN
- Defined:
  - Adds input port mask, width CHANNELS; bit k=1 enables channel k.
  - SCAN advance selects the next enabled index above ch, wrapping to the lowest enabled index. wrap pulses when the chosen index <= the current one.
  - If mask==0: ch holds, cnt keeps counting, no wrap.
  - MANUAL/load of a disabled channel: ch moves to it but y<=0.
  - Mask changes take effect at the next advance.
- Not defined: no mask port; all channels enabled; behaviour exactly as above.

Test Plan:
Setup: WIDTH=4, CHANNELS=4, SEL_W=2, DWELL=3, d={4'hD,4'hC,4'hB,4'hA} (ch0=A).
- Release reset; mode=0, sel=2 -> next edge: ch=2, y=4'hC, valid=1 for 1 cycle; then change ch2 data to 4'h7 -> y=4'h7 one edge later, valid=0.
- Instance with CHANNELS=3: mode=0, sel=1 then sel=3 -> ch stays 1, y stays ch1 data, valid=0.
- mode=1 from ch=0 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 and y A,A,A,B,...,D,A; valid pulses on each change; wrap=1 only on the 3->0 edge.
- Scan at ch=1, cnt=1; pulse load with sel=3 -> next edge ch=3, y=4'hD, cnt=0, wrap=0; ch stays 3 for 3 cycles then 0 with wrap=1.
- Assert reset mid-scan with load=1 -> next edge y=0, ch=0, valid=0, wrap=0; after release with mode=1, first advance occurs 3 cycles later.
- With MUX_SKIP_MASK_EN defined, mask=4'b1010, scan -> ch 1,3,1,3 (3 cycles each), wrap on each 3->1; mask=0 -> ch frozen, no wrap.

Source files
------------

// File: rtl/mux_scan_n.sv
// ---------------------------------------------------------------------------
// mux_scan_n
//   N-channel, W-bit multiplexer with a registered output and a built-in
//   channel sequencer.
//   Manual mode: y follows the channel picked by sel (out-of-range sel ignored).
//   Scan mode: the pointer steps through the channels and dwells DWELL cycles
//   on each. load preloads the pointer from sel.
//
// Optional feature (macro MUX_SKIP_MASK_EN):
//   Adds a per-channel enable mask. Scan skips disabled channels. Selecting a
//   disabled channel manually (or by load) moves ch but drives y to 0.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   d      packed channels, channel k = d[k*WIDTH +: WIDTH]
//   sel    manual select / scan preload value
//   mode   0 = manual, 1 = scan
//   load   scan mode: preload pointer from sel
//   mask   (MUX_SKIP_MASK_EN only) bit k = 1 enables channel k
//   y      registered data of the selected channel
//   ch     channel currently driving y
//   valid  one-cycle pulse when ch changes
//   wrap   one-cycle pulse when the scan pointer returns to the first channel
// ---------------------------------------------------------------------------
module mux_scan_n #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      load,
`ifdef MUX_SKIP_MASK_EN
  input  logic [CHANNELS-1:0]       mask,
`endif
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam int                 CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   CH_LAST  = SEL_W'(CHANNELS - 1);
  // One bit wider than sel so CHANNELS == 2^SEL_W is representable.
  localparam logic [SEL_W:0]     CH_COUNT = (SEL_W + 1)'(CHANNELS);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SEL_W-1:0]  nxt_ch, adv_ch;
  logic              adv_wrap, wrap_nxt, sel_ok;
  logic [WIDTH-1:0]  y_nxt;

  assign sel_ok = ({1'b0, sel} < CH_COUNT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= MANUAL;
    else       state <= state_nxt;
  end

  // Next-state logic: mode is sampled every cycle.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      MANUAL:  if (mode)  state_nxt = SCAN;
      SCAN:    if (!mode) state_nxt = MANUAL;
      default: state_nxt = MANUAL;
    endcase
  end

  // Channel the scan pointer would advance to, and whether that is a wrap.
`ifdef MUX_SKIP_MASK_EN
  always_comb begin : adv_search
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    adv_ch   = ch;
    // Walk upward from ch+1, wrapping around; i == CHANNELS revisits ch
    // itself, so a single enabled channel wraps onto itself.
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ch) + i) % CHANNELS;
      if (!found && mask[idx]) begin
        adv_ch = SEL_W'(idx);
        found  = 1'b1;
      end
    end
    adv_wrap = found && (adv_ch <= ch);
  end
`else
  always_comb begin
    adv_ch   = (ch == CH_LAST) ? '0 : ch + SEL_W'(1);
    adv_wrap = (ch == CH_LAST);
  end
`endif

  // Output logic: the rule of the state being entered applies this cycle.
  always_comb begin
    nxt_ch   = ch;
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    if (state_nxt == MANUAL) begin
      if (sel_ok) nxt_ch = sel;
    end else if (load) begin
      if (sel_ok) nxt_ch = sel;
    end else if (cnt == CNT_LAST) begin
      nxt_ch   = adv_ch;
      wrap_nxt = adv_wrap;
    end else begin
      cnt_nxt  = cnt + CNT_W'(1);
    end

    y_nxt = d[int'(nxt_ch)*WIDTH +: WIDTH];
`ifdef MUX_SKIP_MASK_EN
    if (!mask[int'(nxt_ch)]) y_nxt = '0;
`endif
  end

  // Datapath registers: y and ch load together, so they always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      y     <= '0;
      ch    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      y     <= y_nxt;
      ch    <= nxt_ch;
      cnt   <= cnt_nxt;
      valid <= (nxt_ch != ch);
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_n
//   Directed bench for mux_scan_n. Three instances:
//     dut  : WIDTH=4, CHANNELS=4, SEL_W=2, DWELL=3 (main tests)
//     dut3 : CHANNELS=3 (out-of-range manual select)
//     dut1 : CHANNELS=1, DWELL=2 (single channel wrap cadence)
//   Mask tests run only when MUX_SKIP_MASK_EN is defined.
// ---------------------------------------------------------------------------
module tb_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // main instance
  logic [15:0] d;
  logic [1:0]  sel;
  logic        mode, load;
  logic [3:0]  y;
  logic [1:0]  ch;
  logic        valid, wrap;

  // CHANNELS=3 instance
  logic [11:0] d3;
  logic [1:0]  sel3;
  logic [3:0]  y3;
  logic [1:0]  ch3;
  logic        valid3, wrap3;

  // CHANNELS=1 instance
  logic [3:0]  d1;
  logic        sel1, mode1;
  logic [3:0]  y1;
  logic        ch1;
  logic        valid1, wrap1;

`ifdef MUX_SKIP_MASK_EN
  logic [3:0]  mask;
  logic [2:0]  mask3;
  logic [0:0]  mask1;
`endif

  mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut (
    .clk(clk), .reset(reset), .d(d), .sel(sel), .mode(mode), .load(load),
`ifdef MUX_SKIP_MASK_EN
    .mask(mask),
`endif
    .y(y), .ch(ch), .valid(valid), .wrap(wrap)
  );

  mux_scan_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(3)) dut3 (
    .clk(clk), .reset(reset), .d(d3), .sel(sel3), .mode(1'b0), .load(1'b0),
`ifdef MUX_SKIP_MASK_EN
    .mask(mask3),
`endif
    .y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3)
  );

  mux_scan_n #(.WIDTH(4), .CHANNELS(1), .SEL_W(1), .DWELL(2)) dut1 (
    .clk(clk), .reset(reset), .d(d1), .sel(sel1), .mode(mode1), .load(1'b0),
`ifdef MUX_SKIP_MASK_EN
    .mask(mask1),
`endif
    .y(y1), .ch(ch1), .valid(valid1), .wrap(wrap1)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] dat [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_ch;
  int prev_ch;

  initial begin
    reset = 1'b1;
    d     = 16'hDCBA;
    sel   = 2'd0;
    mode  = 1'b0;
    load  = 1'b0;
    d3    = 12'h654;
    sel3  = 2'd0;
    d1    = 4'h9;
    sel1  = 1'b0;
    mode1 = 1'b0;
`ifdef MUX_SKIP_MASK_EN
    mask  = 4'hF;
    mask3 = 3'b111;
    mask1 = 1'b1;
`endif

    // ---- reset ----
    step(); step();
    check("rst_y",     32'(y),     32'h0);
    check("rst_ch",    32'(ch),    32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_wrap",  32'(wrap),  32'h0);
    check("rst_ch3",   32'(ch3),   32'h0);

    // ---- manual select, data tracking ----
    reset = 1'b0;
    sel   = 2'd2;
    sel3  = 2'd1;
    step();
    check("man_ch",     32'(ch),     32'd2);
    check("man_y",      32'(y),      32'hC);
    check("man_valid",  32'(valid),  32'd1);
    check("man3_ch",    32'(ch3),    32'd1);
    check("man3_y",     32'(y3),     32'h5);
    d    = 16'hD7BA;
    sel3 = 2'd3;   // out of range for CHANNELS=3
    step();
    check("trk_y",      32'(y),      32'h7);
    check("trk_valid",  32'(valid),  32'd0);
    check("trk_ch",     32'(ch),     32'd2);
    check("oor3_ch",    32'(ch3),    32'd1);
    check("oor3_y",     32'(y3),     32'h5);
    check("oor3_valid", 32'(valid3), 32'd0);
    d = 16'hDCBA;

    // ---- single channel: wrap every DWELL=2 cycles, never valid ----
    mode1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("one_wrap",  32'(wrap1),  32'((k % 2) == 0));
      check("one_valid", 32'(valid1), 32'd0);
      check("one_ch",    32'(ch1),    32'd0);
      check("one_y",     32'(y1),     32'h9);
    end
    mode1 = 1'b0;

    // ---- full scan cycle from ch 0 ----
    sel = 2'd0;
    step();
    check("pre_ch",    32'(ch),    32'd0);
    check("pre_valid", 32'(valid), 32'd1);
    mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_ch = (k / 3) % 4;
      check("scan_ch",    32'(ch),    32'(exp_ch));
      check("scan_y",     32'(y),     32'(dat[exp_ch]));
      check("scan_valid", 32'(valid), 32'((k % 3) == 0));
      check("scan_wrap",  32'(wrap),  32'(k == 12));
    end

    // ---- load in the middle of a dwell (ch=1, cnt=1) ----
    step(); step(); step(); step();
    check("ld_pre_ch", 32'(ch), 32'd1);
    load = 1'b1;
    sel  = 2'd3;
    step();
    load = 1'b0;
    check("ld_ch",    32'(ch),    32'd3);
    check("ld_y",     32'(y),     32'hD);
    check("ld_wrap",  32'(wrap),  32'd0);
    check("ld_valid", 32'(valid), 32'd1);
    step();
    check("ld_hold1", 32'(ch), 32'd3);
    step();
    check("ld_hold2", 32'(ch), 32'd3);
    step();
    check("ld_adv_ch",   32'(ch),   32'd0);
    check("ld_adv_y",    32'(y),    32'hA);
    check("ld_adv_wrap", 32'(wrap), 32'd1);

    // ---- reset mid-scan overrides load ----
    step(); step(); step();
    check("mid_ch", 32'(ch), 32'd1);
    reset = 1'b1;
    load  = 1'b1;
    sel   = 2'd3;
    step();
    check("mrst_y",     32'(y),     32'h0);
    check("mrst_ch",    32'(ch),    32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_wrap",  32'(wrap),  32'd0);
    reset = 1'b0;
    load  = 1'b0;
    step();
    check("post_ch1", 32'(ch), 32'd0);
    step();
    check("post_ch2", 32'(ch), 32'd0);
    step();
    check("post_adv", 32'(ch),    32'd1);
    check("post_val", 32'(valid), 32'd1);

    // ---- mode switch mid-dwell discards the partial count ----
    step();            // cnt = 1
    mode = 1'b0;
    sel  = 2'd1;
    step();
    check("msw_man", 32'(ch), 32'd1);
    mode = 1'b1;
    step();
    check("msw_s1", 32'(ch), 32'd1);
    step();
    check("msw_s2", 32'(ch), 32'd1);
    step();
    check("msw_adv", 32'(ch), 32'd2);

`ifdef MUX_SKIP_MASK_EN
    // ---- skip mask: only channels 1 and 3 enabled ----
    mask = 4'b1010;
    step(); step(); step();
    check("msk_first", 32'(ch),   32'd3);
    check("msk_fwrap", 32'(wrap), 32'd0);
    prev_ch = 3;
    for (int g = 0; g < 3; g++) begin
      exp_ch = (prev_ch == 3) ? 1 : 3;
      step();
      check("msk_hold", 32'(ch), 32'(prev_ch));
      step();
      check("msk_hold", 32'(ch), 32'(prev_ch));
      step();
      check("msk_ch",   32'(ch),   32'(exp_ch));
      check("msk_y",    32'(y),    32'(dat[exp_ch]));
      check("msk_wrap", 32'(wrap), 32'(exp_ch < prev_ch));
      prev_ch = exp_ch;
    end
    mask = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      step();
      check("mz_ch",   32'(ch),   32'd1);
      check("mz_wrap", 32'(wrap), 32'd0);
    end
    mask = 4'b1010;
    mode = 1'b0;
    sel  = 2'd2;
    step();
    check("mdis_ch",    32'(ch),    32'd2);
    check("mdis_y",     32'(y),     32'h0);
    check("mdis_valid", 32'(valid), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
